// File: rtl/ex_operand_stage_if.sv
// Bus bundle between ID, the ID/EX operand stage and the MEM/WB forwarding sources.
// The stage itself uses the slave view; whoever drives ID and the bypass network uses master.
interface ex_operand_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      id_valid;
  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic [REG_ADDR_WIDTH-1:0] id_rd;
  logic [DATA_WIDTH-1:0]     id_rs1_data;
  logic [DATA_WIDTH-1:0]     id_rs2_data;
  logic [DATA_WIDTH-1:0]     id_imm;
  logic [DATA_WIDTH-1:0]     id_pc;
  logic                      id_srca_pc;
  logic                      id_alu_src;
  logic [OPCODE_LENGTH-1:0]  id_operation;
  logic                      id_reg_write;
  logic                      id_mem_read;
  logic                      id_mem_write;
  logic                      flush;
  logic                      mem_reg_write;
  logic [REG_ADDR_WIDTH-1:0] mem_rd;
  logic [DATA_WIDTH-1:0]     mem_result;
  logic                      wb_reg_write;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0]     wb_result;
  logic                      stall;
  logic                      ex_valid;
  logic                      ex_reg_write;
  logic                      ex_mem_read;
  logic                      ex_mem_write;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic [DATA_WIDTH-1:0]     SrcA;
  logic [DATA_WIDTH-1:0]     SrcB;
  logic [OPCODE_LENGTH-1:0]  Operation;
  logic [DATA_WIDTH-1:0]     ex_store_data;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, id_pc,
           id_srca_pc, id_alu_src, id_operation, id_reg_write, id_mem_read, id_mem_write,
           flush, mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
    input  stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd,
           SrcA, SrcB, Operation, ex_store_data
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, id_pc,
           id_srca_pc, id_alu_src, id_operation, id_reg_write, id_mem_read, id_mem_write,
           flush, mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
    output stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd,
           SrcA, SrcB, Operation, ex_store_data
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with load-use stall, write-through capture and MEM/WB
// operand forwarding feeding the EX-stage ALU.
module ex_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic clk,
  input  logic rst_n,
  ex_operand_stage_if.slave bus
);

  logic                      valid_q, valid_d;
  logic                      reg_write_q, reg_write_d;
  logic                      mem_read_q, mem_read_d;
  logic                      mem_write_q, mem_write_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [OPCODE_LENGTH-1:0]  op_q, op_d;
  logic [DATA_WIDTH-1:0]     imm_q, imm_d;
  logic [DATA_WIDTH-1:0]     pc_q, pc_d;
  logic                      srca_pc_q, srca_pc_d;
  logic                      alu_src_q, alu_src_d;

  logic [1:0][REG_ADDR_WIDTH-1:0] id_rs;
  logic [1:0][DATA_WIDTH-1:0]     id_rs_data;
  logic [1:0][DATA_WIDTH-1:0]     rs_fwd;

  logic hazard;
  logic bubble;

  assign id_rs[0]      = bus.id_rs1;
  assign id_rs[1]      = bus.id_rs2;
  assign id_rs_data[0] = bus.id_rs1_data;
  assign id_rs_data[1] = bus.id_rs2_data;

  // Both source fields are compared even if the instruction ignores one of them.
  assign hazard = bus.id_valid & valid_q & mem_read_q & (rd_q != '0) &
                  ((rd_q == bus.id_rs1) | (rd_q == bus.id_rs2));
  assign bubble = bus.flush | hazard;
  assign bus.stall = hazard;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      logic [REG_ADDR_WIDTH-1:0] rs_q, rs_d;
      logic [DATA_WIDTH-1:0]     data_q, data_d;
      logic [DATA_WIDTH-1:0]     fwd;
      logic                      wb_hit_id;
      logic                      mem_hit_ex;
      logic                      wb_hit_ex;

      // The register file reads before WB writes, so capture WB's value directly.
      assign wb_hit_id  = bus.wb_reg_write & (bus.wb_rd != '0) & (bus.wb_rd == id_rs[gi]);
      assign mem_hit_ex = bus.mem_reg_write & (bus.mem_rd != '0) & (bus.mem_rd == rs_q);
      assign wb_hit_ex  = bus.wb_reg_write & (bus.wb_rd != '0) & (bus.wb_rd == rs_q);

      always_comb begin
        rs_d   = rs_q;
        data_d = data_q;
        if (!bubble) begin
          rs_d   = id_rs[gi];
          data_d = wb_hit_id ? bus.wb_result : id_rs_data[gi];
        end
      end

      always_comb begin
        fwd = data_q;
        if (mem_hit_ex) begin
          fwd = bus.mem_result;
        end else if (wb_hit_ex) begin
          fwd = bus.wb_result;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rs_q   <= '0;
          data_q <= '0;
        end else begin
          rs_q   <= rs_d;
          data_q <= data_d;
        end
      end

      assign rs_fwd[gi] = fwd;
    end
  endgenerate

  always_comb begin
    valid_d     = bus.id_valid;
    reg_write_d = bus.id_valid & bus.id_reg_write;
    mem_read_d  = bus.id_valid & bus.id_mem_read;
    mem_write_d = bus.id_valid & bus.id_mem_write;
    rd_d        = bus.id_rd;
    op_d        = bus.id_operation;
    imm_d       = bus.id_imm;
    pc_d        = bus.id_pc;
    srca_pc_d   = bus.id_srca_pc;
    alu_src_d   = bus.id_alu_src;
    if (bubble) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      rd_d        = '0;
      op_d        = '0;
      imm_d       = imm_q;
      pc_d        = pc_q;
      srca_pc_d   = srca_pc_q;
      alu_src_d   = alu_src_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rd_q        <= '0;
      op_q        <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      srca_pc_q   <= 1'b0;
      alu_src_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      rd_q        <= rd_d;
      op_q        <= op_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      srca_pc_q   <= srca_pc_d;
      alu_src_q   <= alu_src_d;
    end
  end

  assign bus.ex_valid      = valid_q;
  assign bus.ex_reg_write  = reg_write_q;
  assign bus.ex_mem_read   = mem_read_q;
  assign bus.ex_mem_write  = mem_write_q;
  assign bus.ex_rd         = rd_q;
  assign bus.Operation     = op_q;
  assign bus.SrcA          = srca_pc_q ? pc_q : rs_fwd[0];
  assign bus.SrcB          = alu_src_q ? imm_q : rs_fwd[1];
  assign bus.ex_store_data = rs_fwd[1];

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed vector table, hand-written hazard/flush/reset
// sequences, then random traffic against a register-level reference model.
module tb_ex_operand_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ex_operand_stage_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR_WIDTH(5)) bus ();

  ex_operand_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR_WIDTH(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
    bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0; bus.id_pc = 0;
    bus.id_srca_pc = 0; bus.id_alu_src = 0; bus.id_operation = 0;
    bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0; bus.flush = 0;
    bus.mem_reg_write = 0; bus.mem_rd = 0; bus.mem_result = 0;
    bus.wb_reg_write = 0; bus.wb_rd = 0; bus.wb_result = 0;
  endtask

  task automatic rand_inputs();
    bus.id_valid      = ($urandom_range(0, 7) != 0);
    bus.id_rs1        = 5'($urandom_range(0, 7));
    bus.id_rs2        = 5'($urandom_range(0, 7));
    bus.id_rd         = 5'($urandom_range(0, 7));
    bus.id_rs1_data   = $urandom;
    bus.id_rs2_data   = $urandom;
    bus.id_imm        = $urandom;
    bus.id_pc         = $urandom;
    bus.id_srca_pc    = 1'($urandom_range(0, 1));
    bus.id_alu_src    = 1'($urandom_range(0, 1));
    bus.id_operation  = 4'($urandom);
    bus.id_reg_write  = 1'($urandom_range(0, 1));
    bus.id_mem_read   = ($urandom_range(0, 2) == 0);
    bus.id_mem_write  = ($urandom_range(0, 3) == 0);
    bus.flush         = ($urandom_range(0, 9) == 0);
    bus.mem_reg_write = 1'($urandom_range(0, 1));
    bus.mem_rd        = 5'($urandom_range(0, 7));
    bus.mem_result    = $urandom;
    bus.wb_reg_write  = 1'($urandom_range(0, 1));
    bus.wb_rd         = 5'($urandom_range(0, 7));
    bus.wb_result     = $urandom;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [4:0]  rs1, rs2;
    logic [31:0] d1, d2, imm, pc;
    logic        srca, alusrc;
    logic [3:0]  op;
    logic        flush;
    logic        cwe;  logic [4:0] crd; logic [31:0] cres;   // WB at capture
    logic        mwe;  logic [4:0] mrd; logic [31:0] mres;   // MEM at check
    logic        wwe;  logic [4:0] wrd; logic [31:0] wres;   // WB at check
    logic        ev;
    logic [31:0] ea, eb, es;
    logic [3:0]  eop;
  } vec_t;

  vec_t vecs[9];

  // ---------------- reference model: contents of the EX slot ----------------
  typedef struct {
    logic        valid, rw, mr, mw, srca, alusrc, known;
    logic [4:0]  rd, rs1, rs2;
    logic [3:0]  op;
    logic [31:0] v1, v2, imm, pc;
  } ex_t;

  ex_t m;

  // Architectural value of register r as EX sees it: youngest in-flight writer wins.
  function automatic logic [31:0] newest(input logic [4:0] r, input logic [31:0] stored);
    if (r == 0) return stored;
    if (bus.mem_reg_write && bus.mem_rd == r) return bus.mem_result;
    if (bus.wb_reg_write && bus.wb_rd == r) return bus.wb_result;
    return stored;
  endfunction

  // Register-file read value once this cycle's WB write is accounted for.
  function automatic logic [31:0] rf_read(input logic [4:0] r, input logic [31:0] raw);
    if (r != 0 && bus.wb_reg_write && bus.wb_rd == r) return bus.wb_result;
    return raw;
  endfunction

  function automatic logic load_use();
    return bus.id_valid && m.valid && m.mr && m.rd != 0 &&
           (m.rd == bus.id_rs1 || m.rd == bus.id_rs2);
  endfunction

  initial begin
    logic [31:0] fa, fb;
    logic        exp_stall;

    vecs[0] = '{1,2, 5,9,7,32'h100, 0,1, 4'h2,0, 0,0,0, 0,0,0, 0,0,0, 1, 5,7,9, 4'h2};
    vecs[1] = '{3,4, 1,2,0,0, 0,0, 4'h5,0, 0,0,0, 1,3,32'h55, 1,3,32'h99, 1, 32'h55,2,2, 4'h5};
    vecs[2] = '{3,4, 1,2,0,0, 0,0, 4'h5,0, 0,0,0, 0,3,32'h55, 1,3,32'h99, 1, 32'h99,2,2, 4'h5};
    vecs[3] = '{1,0, 8,0,0,0, 0,0, 4'h6,0, 0,0,0, 1,0,32'hFF, 1,0,32'hEE, 1, 8,0,0, 4'h6};
    vecs[4] = '{7,2, 0,3,0,0, 0,0, 4'h1,0, 1,7,32'hABCD, 0,0,0, 0,0,0, 1, 32'hABCD,3,3, 4'h1};
    vecs[5] = '{6,2, 4,3,32'h10,32'h1000, 1,1, 4'h8,0, 0,0,0, 1,6,32'h66, 0,0,0, 1, 32'h1000,32'h10,3, 4'h8};
    vecs[6] = '{1,4, 1,2,32'h20,0, 0,1, 4'h9,0, 0,0,0, 1,4,32'h77, 1,4,32'h88, 1, 1,32'h20,32'h77, 4'h9};
    vecs[7] = '{1,2, 3,4,0,0, 0,0, 4'hC,1, 0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 4'h0};
    vecs[8] = '{2,9, 32'h11,0,0,0, 0,0, 4'hF,0, 1,9,32'h4444, 1,2,32'h22, 0,0,0, 1, 32'h22,32'h4444,32'h4444, 4'hF};

    // ---- reset state with random inputs ----
    rand_inputs();
    #12;
    chk("rst_ex_valid", {31'b0, bus.ex_valid}, 0);
    chk("rst_operation", {28'b0, bus.Operation}, 0);
    chk("rst_srca", bus.SrcA, 0);
    chk("rst_srcb", bus.SrcB, 0);
    chk("rst_store", bus.ex_store_data, 0);
    chk("rst_stall", {31'b0, bus.stall}, 0);
    $display("[TB] reset state checked");
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ---- table ----
    for (int i = 0; i < 9; i++) begin
      clear_inputs();
      bus.id_valid = 1; bus.id_reg_write = 1; bus.id_rd = 5'd10;
      bus.id_rs1 = vecs[i].rs1; bus.id_rs2 = vecs[i].rs2;
      bus.id_rs1_data = vecs[i].d1; bus.id_rs2_data = vecs[i].d2;
      bus.id_imm = vecs[i].imm; bus.id_pc = vecs[i].pc;
      bus.id_srca_pc = vecs[i].srca; bus.id_alu_src = vecs[i].alusrc;
      bus.id_operation = vecs[i].op; bus.flush = vecs[i].flush;
      bus.wb_reg_write = vecs[i].cwe; bus.wb_rd = vecs[i].crd; bus.wb_result = vecs[i].cres;
      step();
      clear_inputs();
      bus.mem_reg_write = vecs[i].mwe; bus.mem_rd = vecs[i].mrd; bus.mem_result = vecs[i].mres;
      bus.wb_reg_write = vecs[i].wwe; bus.wb_rd = vecs[i].wrd; bus.wb_result = vecs[i].wres;
      #1;
      chk($sformatf("vec%0d_valid", i), {31'b0, bus.ex_valid}, {31'b0, vecs[i].ev});
      chk($sformatf("vec%0d_regwr", i), {31'b0, bus.ex_reg_write}, {31'b0, vecs[i].ev});
      chk($sformatf("vec%0d_op", i), {28'b0, bus.Operation}, {28'b0, vecs[i].eop});
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d_srca", i), bus.SrcA, vecs[i].ea);
        chk($sformatf("vec%0d_srcb", i), bus.SrcB, vecs[i].eb);
        chk($sformatf("vec%0d_store", i), bus.ex_store_data, vecs[i].es);
      end
      $display("[TB] vec %0d: valid=%0d A=%h B=%h store=%h op=%h", i, bus.ex_valid,
               bus.SrcA, bus.SrcB, bus.ex_store_data, bus.Operation);
    end

    // ---- load-use: stall, bubble, then consumer with the loaded value ----
    clear_inputs();
    bus.id_valid = 1; bus.id_rd = 5; bus.id_mem_read = 1; bus.id_reg_write = 1;
    step();
    clear_inputs();
    bus.id_valid = 1; bus.id_rs1 = 1; bus.id_rs1_data = 10; bus.id_rs2 = 5;
    bus.id_operation = 4'h3; bus.id_reg_write = 1; bus.id_rd = 6;
    #1;
    chk("lu_stall", {31'b0, bus.stall}, 1);
    step();
    chk("lu_bubble_valid", {31'b0, bus.ex_valid}, 0);
    chk("lu_bubble_regwr", {31'b0, bus.ex_reg_write}, 0);
    chk("lu_stall_drop", {31'b0, bus.stall}, 0);
    step();
    bus.wb_reg_write = 1; bus.wb_rd = 5; bus.wb_result = 32'h1234;
    step();
    bus.wb_reg_write = 0; bus.id_valid = 0;
    #1;
    chk("lu_consumer_valid", {31'b0, bus.ex_valid}, 1);
    chk("lu_consumer_srcb", bus.SrcB, 32'h1234);
    chk("lu_consumer_srca", bus.SrcA, 10);
    $display("[TB] load-use: valid=%0d A=%h B=%h", bus.ex_valid, bus.SrcA, bus.SrcB);

    // ---- flush together with stall, then a plain flush ----
    clear_inputs();
    bus.id_valid = 1; bus.id_rd = 5; bus.id_mem_read = 1; bus.id_reg_write = 1;
    step();
    clear_inputs();
    bus.id_valid = 1; bus.id_rs1 = 5; bus.id_reg_write = 1; bus.id_rd = 7; bus.flush = 1;
    #1;
    chk("fs_stall", {31'b0, bus.stall}, 1);
    step();
    chk("fs_valid", {31'b0, bus.ex_valid}, 0);
    chk("fs_regwr", {31'b0, bus.ex_reg_write}, 0);
    chk("fs_rd", {27'b0, bus.ex_rd}, 0);
    clear_inputs();
    bus.id_valid = 1; bus.id_rs1 = 2; bus.id_reg_write = 1; bus.id_mem_write = 1;
    bus.id_rd = 3; bus.id_operation = 4'h4; bus.flush = 1;
    step();
    chk("fl_valid", {31'b0, bus.ex_valid}, 0);
    chk("fl_memwr", {31'b0, bus.ex_mem_write}, 0);
    chk("fl_op", {28'b0, bus.Operation}, 0);
    $display("[TB] flush: valid=%0d regwr=%0d", bus.ex_valid, bus.ex_reg_write);

    // ---- mid-operation reset ----
    clear_inputs();
    bus.id_valid = 1; bus.id_rd = 4; bus.id_mem_read = 1; bus.id_reg_write = 1;
    step();
    bus.id_rs1 = 4; bus.id_rd = 1; bus.id_mem_read = 0;
    #1;
    chk("mr_pre_stall", {31'b0, bus.stall}, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_stall", {31'b0, bus.stall}, 0);
    chk("mr_valid", {31'b0, bus.ex_valid}, 0);
    chk("mr_memrd", {31'b0, bus.ex_mem_read}, 0);
    $display("[TB] mid-op reset: stall=%0d valid=%0d", bus.stall, bus.ex_valid);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ---- random traffic against the model ----
    clear_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m = '{valid: 0, rw: 0, mr: 0, mw: 0, srca: 0, alusrc: 0, known: 1,
          rd: 0, rs1: 0, rs2: 0, op: 0, v1: 0, v2: 0, imm: 0, pc: 0};
    step();
    for (int t = 0; t < 250; t++) begin
      rand_inputs();
      #1;
      exp_stall = load_use();
      chk("rnd_stall", {31'b0, bus.stall}, {31'b0, exp_stall});
      chk("rnd_valid", {31'b0, bus.ex_valid}, {31'b0, m.valid});
      chk("rnd_regwr", {31'b0, bus.ex_reg_write}, {31'b0, m.rw});
      chk("rnd_memrd", {31'b0, bus.ex_mem_read}, {31'b0, m.mr});
      chk("rnd_memwr", {31'b0, bus.ex_mem_write}, {31'b0, m.mw});
      chk("rnd_rd", {27'b0, bus.ex_rd}, {27'b0, m.rd});
      chk("rnd_op", {28'b0, bus.Operation}, {28'b0, m.op});
      if (m.known) begin
        fa = newest(m.rs1, m.v1);
        fb = newest(m.rs2, m.v2);
        chk("rnd_srca", bus.SrcA, m.srca ? m.pc : fa);
        chk("rnd_srcb", bus.SrcB, m.alusrc ? m.imm : fb);
        chk("rnd_store", bus.ex_store_data, fb);
      end
      $display("[TB] rnd %0d: stall=%0d valid=%0d A=%h B=%h", t, bus.stall, bus.ex_valid,
               bus.SrcA, bus.SrcB);
      if (bus.flush || exp_stall) begin
        m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.rd = 0; m.op = 0; m.known = 0;
      end else begin
        m.valid  = bus.id_valid;
        m.rw     = bus.id_valid && bus.id_reg_write;
        m.mr     = bus.id_valid && bus.id_mem_read;
        m.mw     = bus.id_valid && bus.id_mem_write;
        m.rd     = bus.id_rd;
        m.op     = bus.id_operation;
        m.rs1    = bus.id_rs1;
        m.rs2    = bus.id_rs2;
        m.v1     = rf_read(bus.id_rs1, bus.id_rs1_data);
        m.v2     = rf_read(bus.id_rs2, bus.id_rs2_data);
        m.imm    = bus.id_imm;
        m.pc     = bus.id_pc;
        m.srca   = bus.id_srca_pc;
        m.alusrc = bus.id_alu_src;
        m.known  = 1;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
